// File: rtl/spi_arb.sv
// spi_arb: two-requester front end for a single SPI master.
// Accepts 16-bit commands from requester 0 (inertial) and requester 1
// (auxiliary client), launches one SPI transaction at a time, returns read
// data and completion to the owner, keeps ownership across locked bursts,
// and releases the bus through a watchdog if the SPI master never finishes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus free; grant a lone request, or !last when both request
// XFER  | transaction in flight; wait for spi_done rising edge or timeout
// HOLD  | owner keeps the bus between locked transactions
module spi_arb #(
    parameter int TMO_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data,
    output logic        err,
    output logic [1:0]  gnt,
    output logic        spi_write_en,
    output logic [15:0] wt_data,
    input  logic        spi_done,
    input  logic [15:0] spi_rd
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int             CNT_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

    logic [1:0]       r_state;
    logic             r_last;
    logic             r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_spi_done_q;

    logic             r_ack0;
    logic             r_ack1;
    logic             r_done0;
    logic             r_done1;
    logic             r_err;
    logic [15:0]      r_rd_data;
    logic [1:0]       r_gnt;
    logic             r_spi_we;
    logic [15:0]      r_wt_data;

    logic             w_spi_rise;
    logic             w_req_own;
    logic             w_lock_own;
    logic             w_pick;
    logic             w_launch;
    logic             w_launch_id;
    logic [15:0]      w_cmd;
    logic             w_complete;
    logic             w_timeout;
    logic             w_finish;
    logic             w_release;
    logic             w_bad_state;
    logic [1:0]       w_state_nxt;

    // Decode arbitration, launch and completion events for the current cycle.
    always_comb begin
        w_spi_rise  = spi_done & ~r_spi_done_q;
        w_req_own   = r_owner ? req1 : req0;
        w_lock_own  = r_owner ? lock1 : lock0;
        // On a tie the requester that did not win last time goes first.
        w_pick      = (req0 & req1) ? ~r_last : req1;
        w_bad_state = (r_state != ST_IDLE) && (r_state != ST_XFER) &&
                      (r_state != ST_HOLD);

        w_launch    = 1'b0;
        w_launch_id = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_release   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_launch    = req0 | req1;
                w_launch_id = w_pick;
            end
            ST_XFER: begin
                // A real completion wins over a coincident watchdog expiry.
                w_complete = w_spi_rise;
                w_timeout  = ~w_spi_rise && (r_cnt == CNT_LAST);
                w_release  = (w_complete & ~w_lock_own) | w_timeout;
            end
            ST_HOLD: begin
                w_launch    = w_req_own;
                w_launch_id = r_owner;
                w_release   = ~w_req_own & ~w_lock_own;
            end
            default: begin
                w_launch    = 1'b0;
                w_launch_id = 1'b0;
            end
        endcase

        w_cmd    = w_launch_id ? cmd1 : cmd0;
        w_finish = w_complete | w_timeout;
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_complete) begin
                    w_state_nxt = w_lock_own ? ST_HOLD : ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (w_launch) begin
                    w_state_nxt = ST_XFER;
                end else if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fairness memory and current owner; a HOLD relaunch keeps both as they are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
        end else if (w_launch && (r_state == ST_IDLE)) begin
            r_last  <= w_pick;
            r_owner <= w_pick;
        end
    end

    // Watchdog: counts cycles spent in XFER since the launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_bad_state || w_launch) begin
            r_cnt <= '0;
        end else if ((r_state == ST_XFER) && !w_finish) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Delayed spi_done for edge detection, tracked in every state so a level
    // left high from the previous transaction is not seen as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spi_done_q <= 1'b0;
        end else begin
            r_spi_done_q <= spi_done;
        end
    end

    // Launch-side outputs: write strobe, command word and acknowledge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spi_we  <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_wt_data <= '0;
        end else if (w_bad_state) begin
            r_spi_we  <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_wt_data <= '0;
        end else begin
            r_spi_we <= w_launch;
            r_ack0   <= w_launch & ~w_launch_id;
            r_ack1   <= w_launch & w_launch_id;
            if (w_launch) begin
                r_wt_data <= w_cmd;
            end
        end
    end

    // Completion-side outputs; a timeout leaves the previous read word in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else if (w_bad_state) begin
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_done0 <= w_finish & ~r_owner;
            r_done1 <= w_finish & r_owner;
            r_err   <= w_timeout;
            if (w_complete) begin
                r_rd_data <= spi_rd;
            end
        end
    end

    // One-hot grant: set on launch, cleared whenever the bus is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= 2'b00;
        end else if (w_bad_state) begin
            r_gnt <= 2'b00;
        end else if (w_launch) begin
            r_gnt <= w_launch_id ? 2'b10 : 2'b01;
        end else if (w_release) begin
            r_gnt <= 2'b00;
        end
    end

    assign ack0         = r_ack0;
    assign ack1         = r_ack1;
    assign done0        = r_done0;
    assign done1        = r_done1;
    assign err          = r_err;
    assign rd_data      = r_rd_data;
    assign gnt          = r_gnt;
    assign spi_write_en = r_spi_we;
    assign wt_data      = r_wt_data;

endmodule
